// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
// The CRC pieces are used only when CCFF_READBACK_CHECK_EN is defined.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } ccff_state_e;

  localparam logic [7:0] CCFF_CRC_POLY = 8'h07;
  localparam logic [7:0] CCFF_CRC_INIT = 8'h00;

  // MSB-first serial CRC-8: the incoming bit is folded in against the top bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Byte-stream valid/ready channel that feeds the bitstream image into the loader.
interface ccff_chain_loader_if;

  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/ccff_chain_loader_crc8.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
// Instantiated by the loader only when CCFF_READBACK_CHECK_EN is defined.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= CCFF_CRC_INIT;
    end else if (clr) begin
      crc <= CCFF_CRC_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises a byte-stream image onto ccff_head, LSB first.
// Define CCFF_READBACK_CHECK_EN to add a CRC-8 readback pass that rotates the chain via ccff_tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int LEN_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clock,
  input  logic               prog_reset_n,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  output logic               config_enable,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(CHAIN_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  ccff_state_e      state;
  ccff_state_e      state_next;
  logic [7:0]       shift_buf;
  logic [LEN_W-1:0] bits_left;
  logic [2:0]       bit_idx;
  logic             last_bit;
  logic             take_byte;
  logic             cfg_ready;
`ifdef CCFF_READBACK_CHECK_EN
  logic             last_rot;
  logic [LEN_W-1:0] rot_cnt;
  logic [7:0]       crc_wr;
  logic [7:0]       crc_rd;
  logic             crc_reset;
  logic             crc_clr;
  logic             crc_wr_en;
  logic             crc_rd_en;
`endif

  assign last_bit      = (state == SHIFT) && (bits_left == LEN_ONE);
  assign take_byte     = (state == LOAD) && cfg.cfg_valid;
  assign cfg.cfg_ready = cfg_ready;

  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend only on registered state, except ccff_head mirroring ccff_tail in VERIFY.
  always_comb begin
    state_next    = state;
    cfg_ready     = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        config_enable = 1'b1;
        ccff_head     = shift_buf[0];
        if (last_bit) begin
`ifdef CCFF_READBACK_CHECK_EN
          state_next = VERIFY;
`else
          state_next = DONE;
`endif
        end else if (bit_idx == 3'd7) begin
          state_next = LOAD;
        end
      end
`ifdef CCFF_READBACK_CHECK_EN
      VERIFY: begin
        config_enable = 1'b1;
        ccff_head     = ccff_tail;
        if (last_rot) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final byte may be partial; bits_left ends the load before its upper bits are shifted.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shift_buf <= '0;
      bits_left <= LEN_INIT;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bits_left <= LEN_INIT;
        end
        LOAD: begin
          if (take_byte) begin
            shift_buf <= cfg.cfg_data;
            bit_idx   <= 3'd0;
          end
        end
        SHIFT: begin
          shift_buf <= {1'b0, shift_buf[7:1]};
          bits_left <= bits_left - LEN_ONE;
          bit_idx   <= bit_idx + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CCFF_READBACK_CHECK_EN
  assign last_rot  = (state == VERIFY) && (rot_cnt == LEN_ONE);
  assign crc_reset = ~prog_reset_n;
  assign crc_clr   = (state == IDLE);
  assign crc_wr_en = (state == SHIFT);
  assign crc_rd_en = (state == VERIFY);

  ccff_crc8_serial u_crc_wr (
    .clock (prog_clock),
    .reset (crc_reset),
    .clr   (crc_clr),
    .en    (crc_wr_en),
    .din   (shift_buf[0]),
    .crc   (crc_wr)
  );

  ccff_crc8_serial u_crc_rd (
    .clock (prog_clock),
    .reset (crc_reset),
    .clr   (crc_clr),
    .en    (crc_rd_en),
    .din   (ccff_tail),
    .crc   (crc_rd)
  );

  // The last readback bit is folded in combinationally so the compare sees all CHAIN_LEN bits.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rot_cnt <= LEN_INIT;
      error   <= 1'b0;
    end else begin
      if (last_bit) begin
        rot_cnt <= LEN_INIT;
      end else if (state == VERIFY) begin
        rot_cnt <= rot_cnt - LEN_ONE;
      end
      if ((state == IDLE) && start) begin
        error <= 1'b0;
      end else if (last_rot) begin
        error <= (crc8_step(crc_rd, ccff_tail) != crc_wr);
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed self-checking bench for ccff_chain_loader at CHAIN_LEN 16, 10 and 1 with model chains.
// Readback-specific expectations follow CCFF_READBACK_CHECK_EN.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_CHECK_EN
  localparam int VERIFY_ON = 1;
`else
  localparam int VERIFY_ON = 0;
`endif

  logic       prog_clock = 1'b0;
  logic       prog_reset_n;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  always #5 prog_clock = ~prog_clock;

  ccff_chain_loader_if if16 ();
  ccff_chain_loader_if if10 ();
  ccff_chain_loader_if if1 ();

  assign if16.cfg_data  = cfg_data;
  assign if16.cfg_valid = cfg_valid;
  assign if10.cfg_data  = cfg_data;
  assign if10.cfg_valid = cfg_valid;
  assign if1.cfg_data   = cfg_data;
  assign if1.cfg_valid  = cfg_valid;

  logic        start16, head16, en16, tail16, busy16, done16, err16;
  logic        start10, head10, en10, tail10, busy10, done10, err10;
  logic        start1, head1, en1, tail1, busy1, done1, err1;
  logic [15:0] chain16 = '0;
  logic [15:0] stuck16 = '0;
  logic [9:0]  chain10 = '0;
  logic        chain1 = 1'b0;

  assign start16 = start & (sel == 0);
  assign start10 = start & (sel == 1);
  assign start1  = start & (sel == 2);
  assign tail16  = chain16[15] | stuck16[15];
  assign tail10  = chain10[9];
  assign tail1   = chain1;

  ccff_chain_loader #(.CHAIN_LEN(16)) dut16 (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .start         (start16),
    .cfg           (if16),
    .ccff_head     (head16),
    .config_enable (en16),
    .ccff_tail     (tail16),
    .busy          (busy16),
    .done          (done16),
    .error         (err16)
  );

  ccff_chain_loader #(.CHAIN_LEN(10)) dut10 (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .start         (start10),
    .cfg           (if10),
    .ccff_head     (head10),
    .config_enable (en10),
    .ccff_tail     (tail10),
    .busy          (busy10),
    .done          (done10),
    .error         (err10)
  );

  ccff_chain_loader #(.CHAIN_LEN(1)) dut1 (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .start         (start1),
    .cfg           (if1),
    .ccff_head     (head1),
    .config_enable (en1),
    .ccff_tail     (tail1),
    .busy          (busy1),
    .done          (done1),
    .error         (err1)
  );

  // Fabric chain models: shift toward the tail on each enabled edge; never reset.
  always @(posedge prog_clock) begin
    if (en16) chain16 <= {chain16[14:0], head16} | stuck16;
    if (en10) chain10 <= {chain10[8:0], head10};
    if (en1)  chain1  <= head1;
  end

  logic cur_en, cur_head, cur_ready, cur_done, cur_err;
  always_comb begin
    cur_en = 1'b0; cur_head = 1'b0; cur_ready = 1'b0; cur_done = 1'b0; cur_err = 1'b0;
    case (sel)
      0: begin cur_en = en16; cur_head = head16; cur_ready = if16.cfg_ready; cur_done = done16; cur_err = err16; end
      1: begin cur_en = en10; cur_head = head10; cur_ready = if10.cfg_ready; cur_done = done10; cur_err = err10; end
      default: begin cur_en = en1; cur_head = head1; cur_ready = if1.cfg_ready; cur_done = done1; cur_err = err1; end
    endcase
  end

  int   en_cnt = 0, done_cnt = 0, ready_cnt = 0, hs_cnt = 0;
  logic heads [1024];
  always @(posedge prog_clock) begin
    if (cur_en) begin
      heads[en_cnt % 1024] <= cur_head;
      en_cnt <= en_cnt + 1;
    end
    if (cur_done) done_cnt <= done_cnt + 1;
    if (cur_ready) ready_cnt <= ready_cnt + 1;
    if (cur_ready && cfg_valid) hs_cnt <= hs_cnt + 1;
  end

  function automatic logic [31:0] heads_from(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = heads[(base + i) % 1024];
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One load on DUT 's': start pulse (with cfg_valid already high in IDLE), bytes offered LSB-byte first,
  // an optional cfg_valid gap of gap_len LOAD cycles before byte 1, and an optional start pulse at edge restart_at.
  task automatic apply_stimulus(input int s, input logic [23:0] bytes, input int n_avail,
                                input int gap_len, input int restart_at, output int k_done,
                                output logic rdy_k1, output logic err_k1, output logic gap_en);
    int idx, gap, k;
    idx = 0; gap = 0; k = 0; gap_en = 1'b0; rdy_k1 = 1'b0; err_k1 = 1'b0;
    sel = s;
    @(negedge prog_clock);
    start = 1'b1; cfg_valid = 1'b1; cfg_data = bytes[7:0];
    @(negedge prog_clock);
    start = 1'b0; k = 1;
    while (!cur_done && k < 400) begin
      if (k == 1) begin rdy_k1 = cur_ready; err_k1 = cur_err; end
      start     = (k == restart_at);
      cfg_valid = (idx < n_avail) && (gap == 0);
      cfg_data  = (idx < 3) ? bytes[idx*8 +: 8] : 8'h00;
      if (cur_ready && !cfg_valid && gap > 0) begin
        gap--;
        gap_en = gap_en | cur_en;
      end
      if (cfg_valid && cur_ready) begin
        idx++;
        if (idx == 1) gap = gap_len;
      end
      @(negedge prog_clock);
      k++;
    end
    start = 1'b0; cfg_valid = 1'b0;
    k_done = k;
    check_output("done_seen", {31'd0, cur_done}, 32'd1);
  endtask

  initial begin
    int   k, b_en, b_done, b_ready, b_hs;
    logic rdy_k1, err_k1, gap_en;
    start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; sel = 0;
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clock);

    $display("[TB] reset values");
    check_output("rst_ready", {31'd0, if16.cfg_ready}, 32'd0);
    check_output("rst_head",  {31'd0, head16}, 32'd0);
    check_output("rst_en",    {31'd0, en16}, 32'd0);
    check_output("rst_busy",  {31'd0, busy16}, 32'd0);
    check_output("rst_done",  {31'd0, done16}, 32'd0);
    check_output("rst_error", {31'd0, err16}, 32'd0);
    prog_reset_n = 1'b1;
    @(negedge prog_clock);

    $display("[TB] basic load, CHAIN_LEN=16, A5 3C");
    b_en = en_cnt; b_done = done_cnt; b_hs = hs_cnt;
    apply_stimulus(0, 24'h00_3CA5, 2, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("basic_ready_latency", {31'd0, rdy_k1}, 32'd1);
    check_output("basic_latency", k, 16 + 2 + 1 + VERIFY_ON * 16);
    check_output("basic_heads", heads_from(b_en, 16), 32'h3CA5);
    check_output("basic_en_cycles", en_cnt - b_en, 16 * (1 + VERIFY_ON));
    check_output("basic_chain", {16'd0, chain16}, 32'hA53C);
    check_output("basic_hs", hs_cnt - b_hs, 2);
    check_output("basic_error", {31'd0, err16}, 32'd0);
    @(negedge prog_clock);
    check_output("basic_done_width", {31'd0, done16}, 32'd0);
    check_output("basic_idle_busy", {31'd0, busy16}, 32'd0);
    check_output("basic_done_pulses", done_cnt - b_done, 1);

    $display("[TB] partial byte, CHAIN_LEN=10, FF 03 (+spare byte)");
    b_en = en_cnt; b_ready = ready_cnt; b_hs = hs_cnt;
    apply_stimulus(1, 24'hEE_03FF, 3, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("part_latency", k, 10 + 2 + 1 + VERIFY_ON * 10);
    check_output("part_heads", heads_from(b_en, 10), 32'h3FF);
    check_output("part_en_cycles", en_cnt - b_en, 10 * (1 + VERIFY_ON));
    check_output("part_hs", hs_cnt - b_hs, 2);
    check_output("part_ready_cycles", ready_cnt - b_ready, 2);
    check_output("part_chain", {22'd0, chain10}, 32'h3FF);
    @(negedge prog_clock);

    $display("[TB] backpressure, 5-cycle valid gap");
    b_en = en_cnt;
    apply_stimulus(0, 24'h00_3CA5, 2, 5, 0, k, rdy_k1, err_k1, gap_en);
    check_output("bp_latency", k, 16 + 2 + 1 + 5 + VERIFY_ON * 16);
    check_output("bp_gap_enable", {31'd0, gap_en}, 32'd0);
    check_output("bp_heads", heads_from(b_en, 16), 32'h3CA5);
    check_output("bp_en_cycles", en_cnt - b_en, 16 * (1 + VERIFY_ON));
    @(negedge prog_clock);

    $display("[TB] start pulsed mid-SHIFT, 81 7E");
    b_en = en_cnt; b_done = done_cnt;
    apply_stimulus(0, 24'h00_7E81, 2, 0, 5, k, rdy_k1, err_k1, gap_en);
    check_output("rs_latency", k, 16 + 2 + 1 + VERIFY_ON * 16);
    check_output("rs_heads", heads_from(b_en, 16), 32'h7E81);
    check_output("rs_chain", {16'd0, chain16}, 32'h817E);
    @(negedge prog_clock);
    check_output("rs_done_pulses", done_cnt - b_done, 1);
    check_output("rs_idle", {31'd0, busy16}, 32'd0);

    $display("[TB] reset mid-SHIFT");
    sel = 0;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h12;
    @(negedge prog_clock);
    start = 1'b0;
    repeat (3) @(negedge prog_clock);
    cfg_valid = 1'b0;
    check_output("mid_shifting", {31'd0, en16}, 32'd1);
    #2 prog_reset_n = 1'b0;
    #1;
    check_output("mid_rst_en", {31'd0, en16}, 32'd0);
    check_output("mid_rst_busy", {31'd0, busy16}, 32'd0);
    check_output("mid_rst_ready", {31'd0, if16.cfg_ready}, 32'd0);
    check_output("mid_rst_head", {31'd0, head16}, 32'd0);
    @(negedge prog_clock);
    prog_reset_n = 1'b1;
    @(negedge prog_clock);
    b_en = en_cnt;
    apply_stimulus(0, 24'h00_3CA5, 2, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("fresh_latency", k, 16 + 2 + 1 + VERIFY_ON * 16);
    check_output("fresh_heads", heads_from(b_en, 16), 32'h3CA5);
    check_output("fresh_chain", {16'd0, chain16}, 32'hA53C);
    @(negedge prog_clock);

    $display("[TB] CHAIN_LEN=1, 01 (+spare byte)");
    b_en = en_cnt; b_hs = hs_cnt;
    apply_stimulus(2, 24'h00_FF01, 2, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("len1_latency", k, 1 + 1 + 1 + VERIFY_ON);
    check_output("len1_head", heads_from(b_en, 1), 32'h1);
    check_output("len1_en_cycles", en_cnt - b_en, 1 + VERIFY_ON);
    check_output("len1_hs", hs_cnt - b_hs, 1);
    check_output("len1_chain", {31'd0, chain1}, 32'd1);
    @(negedge prog_clock);

`ifdef CCFF_READBACK_CHECK_EN
    $display("[TB] readback with tail flop stuck at 1, image 00 00");
    stuck16 = 16'h8000;
    apply_stimulus(0, 24'h00_0000, 2, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("fault_latency", k, 16 + 2 + 1 + 16);
    @(negedge prog_clock);
    check_output("fault_error", {31'd0, err16}, 32'd1);
    stuck16 = 16'h0000;
    apply_stimulus(0, 24'h00_3CA5, 2, 0, 0, k, rdy_k1, err_k1, gap_en);
    check_output("fault_clear_on_start", {31'd0, err_k1}, 32'd0);
    check_output("heal_chain", {16'd0, chain16}, 32'hA53C);
    @(negedge prog_clock);
    check_output("heal_error", {31'd0, err16}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the fabric logic tiles. It accepts the bitstream image as a byte stream over a valid/ready handshake and serialises it onto the tile's `ccff_head`. While each bit is being shifted it drives `config_enable`. Optionally it verifies the loaded chain by recirculating it through `ccff_tail` and comparing CRCs.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: number of configuration flops in the chain; must be ≥1.
- `LEN_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clock` in 1: programming clock. Single clock domain.
- `prog_reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse that begins a load. Ignored while `busy`.
- `cfg_data` in 8: image byte. Bit 0 is shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a byte this cycle.
- `ccff_head` out 1: serial data into the chain.
- `config_enable` out 1: chain shift enable.
- `ccff_tail` in 1: serial data out of the chain.
- `busy` out 1: high from start acceptance until return to IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky readback mismatch flag.

## Operation
FSM states: IDLE, LOAD, SHIFT, VERIFY, DONE.
- **IDLE**
  - `start` → LOAD.
  - Initialise `bits_left` := CHAIN_LEN.
  - Clear `error` and the CRC registers.
- **LOAD**
  - `cfg_ready` = 1.
  - On `cfg_valid & cfg_ready`: capture the byte into the 8-bit shift buffer, set `bit_idx` := 0, go to SHIFT.
  - `cfg_valid` low: wait indefinitely.
- **SHIFT** (one bit per cycle)
  - `config_enable` = 1, `ccff_head` = `buf[0]`.
  - Each cycle: buffer shifts right, `bits_left` decrements, `bit_idx` increments.
  - Transition after the bit where `bits_left` reaches 0:
    - macro defined → VERIFY, with `rot_cnt` := CHAIN_LEN;
    - otherwise → DONE.
  - Transition after the bit where `bit_idx` = 7 (and `bits_left` not 0) → LOAD.
- **Image size and ordering**
  - The image occupies ceil(CHAIN_LEN/8) bytes.
  - Unused upper bits of the final byte are discarded and never shifted.
  - Bit 0 of byte 0 ends up deepest in the chain, i.e. the first to emerge at `ccff_tail`.
- **VERIFY**: see Configuration.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - Next state IDLE.
- **Output decode outside active states**
  - `ccff_head` = 0 and `config_enable` = 0 in IDLE, LOAD and DONE.
  - `busy` = 1 in every state except IDLE.
- **Boundary cases**
  - `start` while busy: ignored.
  - `cfg_valid` outside LOAD: no effect, and no byte is consumed.
  - CHAIN_LEN = 1: exactly one byte is accepted and one bit is shifted.
  - Reset mid-load: immediately returns to IDLE, all outputs go to their reset values, and the partial chain contents are left as-is.

## Timing
- **Reset values:** `cfg_ready` 0, `ccff_head` 0, `config_enable` 0, `busy` 0, `done` 0, `error` 0, state IDLE.
- **Output decode:** outputs are decoded from registered state and counters only. The one exception is `ccff_head` in VERIFY, which is a combinational copy of `ccff_tail`.
- **Start latency:** `start` sampled at edge N → `cfg_ready` high from cycle N+1.
- **Per-byte cost:** 1 LOAD cycle (when `cfg_valid` is already high) plus 8 SHIFT cycles, so 9 cycles per full byte.
- **Shift sampling:** the chain samples `ccff_head` on the `prog_clock` edge at the end of each `config_enable`-high cycle.
- **Total load time** with `cfg_valid` held high: CHAIN_LEN + ceil(CHAIN_LEN/8) + 2 cycles from start to `done`, plus CHAIN_LEN cycles with verify compiled in.

## Configuration
- **Macro:** `CCFF_READBACK_CHECK_EN`.
- **With the macro defined:**
  - Serial CRC-8 (poly 0x07, init 0x00) is computed over every bit shifted in SHIFT, giving `crc_wr`.
  - VERIFY runs for CHAIN_LEN cycles:
    - `config_enable` = 1 and `ccff_head` = `ccff_tail`, so the chain rotates back to its loaded state;
    - the same CRC is computed over `ccff_tail`, giving `crc_rd`.
  - At the last VERIFY cycle: `error` := (`crc_rd` ≠ `crc_wr`), then go to DONE.
  - `error` holds until the next accepted `start` or reset.
- **Without the macro:**
  - No VERIFY state and no CRC logic.
  - `error` is tied to 0.
  - `ccff_tail` is unused.

## Structure
- **Package `ccff_loader_pkg`:**
  - state enum;
  - `CCFF_CRC_POLY = 8'h07`;
  - `CCFF_CRC_INIT = 8'h00`;
  - function `crc8_step(crc, bit)`.
- **Sub-module `ccff_crc8_serial`:**
  - ports: clock, reset, `clr`, `en`, `din`, `crc[7:0]`;
  - instantiated twice (`crc_wr` and `crc_rd`), only under `CCFF_READBACK_CHECK_EN`.

## Test plan
- **Basic load:** CHAIN_LEN=16, bytes 0xA5, 0x3C, `cfg_valid` held high → `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `config_enable` high for exactly 16 cycles; one `done` pulse; model chain equals the image.
- **Partial byte:** CHAIN_LEN=10, bytes 0xFF, 0x03 → exactly 10 bits shifted and exactly 2 handshakes; the `cfg_ready` count equals the accepted byte count.
- **Backpressure:** `cfg_valid` deasserted for 5 cycles between bytes → `config_enable` stays low during the gap and the bit sequence is unchanged.
- **Start while busy / reset mid-load:**
  - `start` pulsed mid-SHIFT → ignored.
  - `prog_reset_n` low mid-SHIFT → `config_enable`, `busy` and `cfg_ready` are 0 in the same cycle.
  - A fresh load after reset completes correctly.
- **Readback pass (macro on):** healthy model chain → chain contents identical after VERIFY, `error` = 0, and the `done` pulse comes CHAIN_LEN cycles later than with the macro off.
- **Readback fault (macro on):** model chain with one flop stuck at 1 and image 0x00 → `error` = 1 after `done`, cleared on the next `start`.
